// File: rtl/div_unit_seq_if.sv
// Execute-stage handshake for the sequential divider: one-cycle start with operands,
// busy as the stall request, done pulse with a held result.
interface div_unit_seq_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start_i;
    logic [1:0]            op_i;
    logic [DATA_WIDTH-1:0] dividend_i;
    logic [DATA_WIDTH-1:0] divisor_i;
    logic                  flush_i;
    logic                  busy_o;
    logic                  done_o;
    logic [DATA_WIDTH-1:0] result_o;

    modport master (
        output start_i, op_i, dividend_i, divisor_i, flush_i,
        input  busy_o, done_o, result_o
    );

    modport slave (
        input  start_i, op_i, dividend_i, divisor_i, flush_i,
        output busy_o, done_o, result_o
    );
endinterface

// File: rtl/div_unit_seq.sv
// RV32M DIV/DIVU/REM/REMU restoring divider; DATA_WIDTH+2 cycles normal, 1 cycle for /0 and overflow.
// No queueing: start is ignored while busy_o is high; flush aborts to IDLE without done_o.
module div_unit_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_W      = $clog2(DATA_WIDTH) + 1
) (
    input  logic           clk,
    input  logic           rst,
    div_unit_seq_if.slave  bus
);
    localparam logic [1:0] OP_DIV = 2'b00;
    localparam logic [1:0] OP_REM = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [1:0]            r_op;
    logic                  r_sa;
    logic                  r_sb;
    logic [DATA_WIDTH-1:0] r_rem;
    logic [DATA_WIDTH-1:0] r_quo;
    logic [DATA_WIDTH-1:0] r_div;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_result;

    logic                  w_accept;
    logic                  w_busy;
    logic                  w_done;
    logic                  w_sa;
    logic                  w_sb;
    logic [DATA_WIDTH-1:0] w_mag_a;
    logic [DATA_WIDTH-1:0] w_mag_b;
    logic                  w_div_zero;
    logic                  w_ovf;
    logic                  w_fast;
    logic [DATA_WIDTH-1:0] w_fast_res;
    logic [DATA_WIDTH:0]   w_shift;
    logic [DATA_WIDTH:0]   w_diff;
    logic [DATA_WIDTH-1:0] w_quo_s;
    logic [DATA_WIDTH-1:0] w_rem_s;
    logic [DATA_WIDTH-1:0] w_fix_res;

    assign w_accept   = bus.start_i && !bus.flush_i && (r_state == S_IDLE || r_state == S_DONE);
    // Sign flags only exist for the signed ops (op_i[0]==0).
    assign w_sa       = !bus.op_i[0] && bus.dividend_i[DATA_WIDTH-1];
    assign w_sb       = !bus.op_i[0] && bus.divisor_i[DATA_WIDTH-1];
    assign w_mag_a    = w_sa ? (~bus.dividend_i + 1'b1) : bus.dividend_i;
    assign w_mag_b    = w_sb ? (~bus.divisor_i + 1'b1) : bus.divisor_i;
    assign w_div_zero = (bus.divisor_i == '0);
    assign w_ovf      = !bus.op_i[0]
                        && (bus.dividend_i == {1'b1, {(DATA_WIDTH-1){1'b0}}})
                        && (bus.divisor_i == '1);
    assign w_fast     = w_div_zero || w_ovf;

    always_comb begin
        w_fast_res = '0;
        if (w_div_zero)
            w_fast_res = bus.op_i[1] ? bus.dividend_i : '1;
        else if (!bus.op_i[1])
            w_fast_res = bus.dividend_i;
    end

    assign w_shift   = {r_rem, r_quo[DATA_WIDTH-1]};
    assign w_diff    = w_shift - {1'b0, r_div};
    assign w_quo_s   = (r_op == OP_DIV && (r_sa ^ r_sb)) ? (~r_quo + 1'b1) : r_quo;
    assign w_rem_s   = (r_op == OP_REM && r_sa) ? (~r_rem + 1'b1) : r_rem;
    assign w_fix_res = r_op[1] ? w_rem_s : w_quo_s;

    always_ff @(posedge clk) begin
        if (!rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept)
                    w_next = w_fast ? S_DONE : S_CALC;
            end
            S_CALC: begin
                w_busy = 1'b1;
                if (r_cnt == CNT_W'(1))
                    w_next = S_FIX;
            end
            S_FIX: begin
                w_busy = 1'b1;
                w_next = S_DONE;
            end
            S_DONE: begin
                w_done = 1'b1;
                if (w_accept)
                    w_next = w_fast ? S_DONE : S_CALC;
                else
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (bus.flush_i)
            w_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_op     <= '0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op  <= bus.op_i;
            r_sa  <= w_sa;
            r_sb  <= w_sb;
            r_rem <= '0;
            r_quo <= w_mag_a;
            r_div <= w_mag_b;
            r_cnt <= CNT_W'(DATA_WIDTH);
            if (w_fast)
                r_result <= w_fast_res;
        end else if (r_state == S_CALC && !bus.flush_i) begin
            r_cnt <= r_cnt - 1'b1;
            if (!w_diff[DATA_WIDTH]) begin
                r_rem <= w_diff[DATA_WIDTH-1:0];
                r_quo <= {r_quo[DATA_WIDTH-2:0], 1'b1};
            end else begin
                r_rem <= w_shift[DATA_WIDTH-1:0];
                r_quo <= {r_quo[DATA_WIDTH-2:0], 1'b0};
            end
        end else if (r_state == S_FIX && !bus.flush_i) begin
            r_result <= w_fix_res;
        end
    end

    assign bus.busy_o   = w_busy;
    assign bus.done_o   = w_done;
    assign bus.result_o = r_result;
endmodule
